// File: rtl/tpu_sequencer.sv
// tpu_sequencer: program sequencer driving the systolic array strobes from a DMA-loaded instruction memory.
// Optional feature macro: TPU_SEQ_STALL_EN adds a stall_i input that freezes FETCH/EXEC progress.
module tpu_sequencer #(
  parameter int INSTR_W    = 8,
  parameter int OPND_W     = INSTR_W - 3,
  parameter int IMEM_DEPTH = 16,
  parameter int IMEM_AW    = $clog2(IMEM_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               prog_we_i,
  input  logic [IMEM_AW-1:0] prog_addr_i,
  input  logic [INSTR_W-1:0] prog_data_i,
  output logic               prog_err_o,
  input  logic               start_i,
`ifdef TPU_SEQ_STALL_EN
  input  logic               stall_i,
`endif
  output logic               busy_o,
  output logic               done_o,
  output logic [IMEM_AW-1:0] pc_o,
  output logic [OPND_W-1:0]  base_address_o,
  output logic               load_weight_o,
  output logic               load_input_o,
  output logic               valid_o,
  output logic               store_res_o,
  output logic               capture_res_o,
  output logic               clear_acc_o
);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_t;
  state_t             state_q;
  logic [IMEM_AW-1:0] pc_q;
  logic [OPND_W-1:0]  cnt_q;
  logic [INSTR_W-1:0] ir_q;
  logic [OPND_W-1:0]  base_q;
  logic               err_q;
  logic [INSTR_W-1:0] imem [IMEM_DEPTH];
  logic [2:0]         opc;
  logic [OPND_W-1:0]  opnd;
  logic               halt, last, hold, addr_ok, wr_ok, exec_on;
`ifdef TPU_SEQ_STALL_EN
  assign hold = stall_i;
`else
  assign hold = 1'b0;
`endif
  assign opc     = ir_q[INSTR_W-1 -: 3];
  assign opnd    = ir_q[OPND_W-1:0];
  assign halt    = opc == 3'd0 && &opnd;
  assign last    = opc == 3'd3 || opc == 3'd7 || halt || cnt_q == opnd;
  assign addr_ok = 32'(prog_addr_i) < IMEM_DEPTH;
  assign wr_ok   = prog_we_i && state_q == IDLE && addr_ok;
  assign exec_on = state_q == EXEC && !hold;
  assign busy_o         = state_q == FETCH || state_q == EXEC;
  assign done_o         = state_q == DONE;
  assign pc_o           = pc_q;
  assign base_address_o = base_q;
  assign prog_err_o     = err_q;
  assign load_weight_o  = exec_on && opc == 3'd1;
  assign load_input_o   = exec_on && opc == 3'd2;
  assign valid_o        = exec_on && opc == 3'd4;
  assign store_res_o    = exec_on && opc == 3'd5;
  assign capture_res_o  = exec_on && opc == 3'd6;
  assign clear_acc_o    = exec_on && opc == 3'd7;
  // Program memory: writable only while idle, contents survive reset
  always_ff @(posedge clk)
    if (wr_ok) imem[prog_addr_i] <= prog_data_i;
  // Control FSM: fetch/execute loop with per-instruction cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      ir_q    <= '0;
      base_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= prog_we_i && (state_q != IDLE || !addr_ok);
      case (state_q)
        IDLE: if (start_i) begin
          pc_q    <= '0;
          state_q <= FETCH;
        end
        FETCH: if (!hold) begin
          ir_q    <= imem[pc_q];
          cnt_q   <= '0;
          state_q <= EXEC;
        end
        EXEC: if (!hold) begin
          if (opc == 3'd3) base_q <= opnd;
          if (!last) cnt_q <= cnt_q + 1'b1;
          else if (halt || pc_q == IMEM_AW'(IMEM_DEPTH - 1)) state_q <= DONE;
          else begin
            pc_q    <= pc_q + 1'b1;
            state_q <= FETCH;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
